recip_nr_unit: RTL

- Parametrised sequential reciprocal unit for normalised fixed-point operands.
- Takes d in [1,2) as unsigned Q1.(W-1) and returns r ≈ 1/d as unsigned Q1.(W-1).
- Seeds r from a midpoint reciprocal LUT indexed by the top fraction bits of d, then refines it with ITERS Newton-Raphson steps on a single shared multiplier.
- Sits between the operand-normalisation stage and the divider/scaling datapath, with valid/ready handshakes on both sides.

---
 rtl/recip_pkg.sv | 25 ++
 rtl/recip_seed_lut.sv | 21 ++
 rtl/recip_nr_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/recip_pkg.sv
// Shared types and elaboration-time helpers for the Newton-Raphson reciprocal unit.
// Seeds are midpoint reciprocals of each LUT bucket, rounded to nearest.
package recip_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ITER_A = 2'd1,
      ST_ITER_B = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   function automatic logic [63:0] one_q(input int w);
      return 64'd1 << (w - 1);
   endfunction

   // 2^(W-1) / (1 + (idx+0.5)/2^L) == 2^(W+L) / (2^(L+1) + 2*idx + 1); den is odd so no ties
   function automatic logic [63:0] recip_seed(input int idx, input int w, input int lut_bits);
      logic [63:0] num;
      logic [63:0] den;
      num = 64'd1 << (w + lut_bits);
      den = (64'd1 << (lut_bits + 1)) + 64'(2 * idx + 1);
      return (num + (den >> 1)) / den;
   endfunction

endpackage

// File: rtl/recip_seed_lut.sv
// Seed ROM for reciprocal refinement; purely combinational, zero latency, no backpressure.
// Contents are fixed at elaboration from recip_seed().
module recip_seed_lut
   import recip_pkg::*;
#(
   parameter int W        = 16,
   parameter int LUT_BITS = 4
) (
   input  logic [LUT_BITS-1:0] idx_i,
   output logic [W-1:0]        seed_o
);

   logic [W-1:0] rom [2**LUT_BITS];

   for (genvar i = 0; i < 2**LUT_BITS; i++) begin : g_rom
      assign rom[i] = W'(recip_seed(i, W, LUT_BITS));
   end

   assign seed_o = rom[idx_i];

endmodule

// File: rtl/recip_nr_unit.sv
// Sequential reciprocal of d in [1,2): LUT seed + ITERS Newton-Raphson steps on one multiplier.
// Latency 1+2*ITERS (1 for unnormalised input); one operand in flight, result held until out_ready.
module recip_nr_unit
   import recip_pkg::*;
#(
   parameter int W        = 16,
   parameter int LUT_BITS = 4,
   parameter int ITERS    = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_d,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_r,
   output logic         out_err
);

   localparam int            CW  = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam logic [W-1:0]  ONE = W'(one_q(W));
   localparam logic [W:0]    TWO = {1'b1, {W{1'b0}}};

   state_e          state_q, state_d;
   logic [W-1:0]    d_q, d_d;
   logic [W-1:0]    x_q, x_d;
   logic [W:0]      e_q, e_d;
   logic            err_q, err_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [W-1:0]    seed;
   logic [W:0]      mul_b;
   logic [2*W:0]    prod;
   logic [W:0]      p;
   logic [W+1:0]    xs;

   recip_seed_lut #(
      .W        (W),
      .LUT_BITS (LUT_BITS)
   ) u_seed (
      .idx_i  (in_d[W-2 -: LUT_BITS]),
      .seed_o (seed)
   );

   // The single multiplier: x*d in ITER_A, x*e in ITER_B
   assign mul_b = (state_q == ST_ITER_A) ? {1'b0, d_q} : e_q;
   assign prod  = (2*W+1)'(x_q) * (2*W+1)'(mul_b);
   assign p     = (W+1)'(prod >> (W - 1));
   assign xs    = (W+2)'(prod >> (W - 1));

   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      x_d     = x_q;
      e_d     = e_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               d_d   = in_d;
               err_d = ~in_d[W-1];
               cnt_d = '0;
               if (!in_d[W-1]) begin
                  x_d     = '1;
                  state_d = ST_DONE;
               end else begin
                  x_d     = seed;
                  state_d = (ITERS == 0) ? ST_DONE : ST_ITER_A;
               end
            end
         end
         ST_ITER_A: begin
            e_d     = TWO - p;
            state_d = ST_ITER_B;
         end
         ST_ITER_B: begin
            x_d     = (xs > (W+2)'(ONE)) ? ONE : xs[W-1:0];
            cnt_d   = cnt_q + CW'(1);
            state_d = (int'(cnt_q) == ITERS - 1) ? ST_DONE : ST_ITER_A;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         d_q     <= '0;
         x_q     <= '0;
         e_q     <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         x_q     <= x_d;
         e_q     <= e_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE) && !reset;
   assign out_valid = (state_q == ST_DONE);
   assign out_r     = x_q;
   assign out_err   = err_q;

endmodule
